// File: rtl/hdmi_tx_formatter_if.sv
// Video-in / HDMI-out signal bundle for the HDMI transmit formatter.
// Purely combinational grouping; the formatter adds the pipeline latency.
// No handshake: one sample per clock in each direction, never stalled.
interface hdmi_tx_formatter_if;
    logic [31:0] vid_data;
    logic        vid_datavalid;
    logic        vid_h_sync;
    logic        vid_v_sync;
    logic        vid_f;
    logic        vid_h;
    logic        vid_v;
    logic [23:0] hdmi_d;
    logic        hdmi_de;
    logic        hdmi_hs;
    logic        hdmi_vs;

    // Video source side: drives the TFT stream, observes the HDMI pins.
    modport master (
        output vid_data, vid_datavalid, vid_h_sync, vid_v_sync, vid_f, vid_h, vid_v,
        input  hdmi_d, hdmi_de, hdmi_hs, hdmi_vs
    );

    // Formatter side: consumes the TFT stream, drives the HDMI pins.
    modport slave (
        input  vid_data, vid_datavalid, vid_h_sync, vid_v_sync, vid_f, vid_h, vid_v,
        output hdmi_d, hdmi_de, hdmi_hs, hdmi_vs
    );
endinterface

// File: rtl/hdmi_tx_formatter.sv
// TFT video to parallel HDMI pins: polarity fix, underflow blanking, geometry/lock/frame status.
// Latency: 2 cycles on RGB/DE/HS/VS; status updates 2 cycles after a vid_v_sync rise.
// Backpressure: none; one input sample is consumed every cycle.
module hdmi_tx_formatter #(
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0,
    parameter int CNT_W  = 12
) (
    input  logic               clk,
    input  logic               reset,
    hdmi_tx_formatter_if.slave bus,
    input  logic               underflow,
    input  logic               underflow_clr,
    output logic [CNT_W-1:0]   meas_h_active,
    output logic [CNT_W-1:0]   meas_v_active,
    output logic               meas_valid,
    output logic               lock,
    output logic [15:0]        frame_cnt,
    output logic               underflow_sticky
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_CHECK  = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Alpha byte and field/blanking flags are accepted only for port compatibility.
    logic unused_inputs;
    assign unused_inputs = ^{bus.vid_data[31:24], bus.vid_f, bus.vid_h, bus.vid_v};

    // Pixel pipeline flops
    logic [23:0] s1_dat_q, s1_dat_d, out_dat_q, out_dat_d;
    logic        s1_de_q, s1_de_d, out_de_q, out_de_d;
    logic        s1_hs_q, s1_hs_d, out_hs_q, out_hs_d;
    logic        s1_vs_q, s1_vs_d, out_vs_q, out_vs_d;

    // Edge detection and measurement flops
    logic             vs_dly_q, vs_dly_d, vs_dly2_q, vs_dly2_d;
    logic             dv_dly_q, dv_dly_d;
    logic             vs_rise, dv_fall;
    logic [CNT_W-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d, line_len_q, line_len_d;
    logic [CNT_W-1:0] meas_h_q, meas_h_d, meas_v_q, meas_v_d;
    logic             meas_valid_q, meas_valid_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic             blank_q, blank_d;
    logic             sticky_q, sticky_d;

    // Lock FSM
    state_t state_q, state_d;
    logic   capture, pair_match;

    // vs_rise lags vid_v_sync by one cycle through the registered copy; DE fall is seen on the first low cycle.
    assign vs_rise    = vs_dly_q & ~vs_dly2_q;
    assign dv_fall    = dv_dly_q & ~bus.vid_datavalid;
    assign pair_match = (line_len_q == meas_h_q) && (vcnt_q == meas_v_q);

    // Blank flag, sticky flag and edge-history next state; a new underflow beats any clear.
    always_comb begin
        vs_dly_d  = bus.vid_v_sync;
        vs_dly2_d = vs_dly_q;
        dv_dly_d  = bus.vid_datavalid;
        blank_d   = blank_q;
        if (underflow)    blank_d = 1'b1;
        else if (vs_rise) blank_d = 1'b0;
        sticky_d  = sticky_q;
        if (underflow)          sticky_d = 1'b1;
        else if (underflow_clr) sticky_d = 1'b0;
    end

    // Two-stage pixel pipeline; blanking applies to the sample of the cycle in which it is in force.
    always_comb begin
        s1_dat_d  = blank_d ? 24'h0 : bus.vid_data[23:0];
        s1_de_d   = bus.vid_datavalid;
        s1_hs_d   = bus.vid_h_sync;
        s1_vs_d   = bus.vid_v_sync;
        out_dat_d = s1_dat_q;
        out_de_d  = s1_de_q;
        out_hs_d  = HS_POL ? s1_hs_q : ~s1_hs_q;
        out_vs_d  = VS_POL ? s1_vs_q : ~s1_vs_q;
    end

    // Line/frame counters; vs_rise clears both counters and takes priority over a coincident DE fall.
    always_comb begin
        hcnt_d      = hcnt_q;
        vcnt_d      = vcnt_q;
        line_len_d  = line_len_q;
        frame_cnt_d = frame_cnt_q;
        if (bus.vid_datavalid && (hcnt_q != CNT_MAX)) hcnt_d = hcnt_q + 1'b1;
        if (dv_fall) begin
            line_len_d = hcnt_q;
            hcnt_d     = '0;
            if (vcnt_q != CNT_MAX) vcnt_d = vcnt_q + 1'b1;
        end
        if (vs_rise) begin
            hcnt_d      = '0;
            vcnt_d      = '0;
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    // Lock FSM next state; an underflow after the discarded partial frame forces re-verification.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (vs_rise) state_d = ST_FIRST;
            ST_FIRST:  if (vs_rise) state_d = ST_CHECK;
            ST_CHECK:  if (vs_rise && pair_match) state_d = ST_LOCKED;
            ST_LOCKED: if (vs_rise && !pair_match) state_d = ST_CHECK;
            default:   state_d = ST_IDLE;
        endcase
        if (underflow && (state_q != ST_IDLE)) state_d = ST_CHECK;
    end

    // Lock FSM outputs: every frame edge after the partial one captures geometry.
    always_comb begin
        capture      = vs_rise && (state_q != ST_IDLE);
        lock         = (state_q == ST_LOCKED);
        meas_h_d     = capture ? line_len_q : meas_h_q;
        meas_v_d     = capture ? vcnt_q : meas_v_q;
        meas_valid_d = meas_valid_q | capture;
    end

    // Lock FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Pixel pipeline registers; syncs reset to their inactive output levels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_dat_q  <= 24'h0;
            s1_de_q   <= 1'b0;
            s1_hs_q   <= 1'b0;
            s1_vs_q   <= 1'b0;
            out_dat_q <= 24'h0;
            out_de_q  <= 1'b0;
            out_hs_q  <= ~HS_POL;
            out_vs_q  <= ~VS_POL;
        end else begin
            s1_dat_q  <= s1_dat_d;
            s1_de_q   <= s1_de_d;
            s1_hs_q   <= s1_hs_d;
            s1_vs_q   <= s1_vs_d;
            out_dat_q <= out_dat_d;
            out_de_q  <= out_de_d;
            out_hs_q  <= out_hs_d;
            out_vs_q  <= out_vs_d;
        end
    end

    // Measurement, status and edge-history registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_dly_q     <= 1'b0;
            vs_dly2_q    <= 1'b0;
            dv_dly_q     <= 1'b0;
            hcnt_q       <= '0;
            vcnt_q       <= '0;
            line_len_q   <= '0;
            meas_h_q     <= '0;
            meas_v_q     <= '0;
            meas_valid_q <= 1'b0;
            frame_cnt_q  <= 16'h0;
            blank_q      <= 1'b0;
            sticky_q     <= 1'b0;
        end else begin
            vs_dly_q     <= vs_dly_d;
            vs_dly2_q    <= vs_dly2_d;
            dv_dly_q     <= dv_dly_d;
            hcnt_q       <= hcnt_d;
            vcnt_q       <= vcnt_d;
            line_len_q   <= line_len_d;
            meas_h_q     <= meas_h_d;
            meas_v_q     <= meas_v_d;
            meas_valid_q <= meas_valid_d;
            frame_cnt_q  <= frame_cnt_d;
            blank_q      <= blank_d;
            sticky_q     <= sticky_d;
        end
    end

    assign bus.hdmi_d       = out_dat_q;
    assign bus.hdmi_de      = out_de_q;
    assign bus.hdmi_hs      = out_hs_q;
    assign bus.hdmi_vs      = out_vs_q;
    assign meas_h_active    = meas_h_q;
    assign meas_v_active    = meas_v_q;
    assign meas_valid       = meas_valid_q;
    assign frame_cnt        = frame_cnt_q;
    assign underflow_sticky = sticky_q;

endmodule

// File: doc/hdmi_tx_formatter.md
# hdmi_tx_formatter

Downstream stage of the SoC video path. It takes the 32-bit clocked-video TFT stream (`vid_data`, `vid_datavalid`, syncs, `underflow`) and drives the 24-bit parallel HDMI transmitter pins with fixed-latency, polarity-corrected, re-registered RGB, DE, HS and VS. It also measures active frame geometry, counts frames, tracks timing lock and blanks corrupted video after a frame-buffer underflow, and exposes all of this as status for the HPS.

## Interface
- `HS_POL`, 0: output HS active level (0 = active-low, 1 = active-high).
- `VS_POL`, 0: output VS active level (0 = active-low, 1 = active-high).
- `CNT_W`, 12: width of the geometry counters and measurements.
- `clk`  in  1  video pixel clock, the same clock as the TFT `vid_clk`.
- `reset`  in  1  reset, asynchronous and active-high.
- `vid_data`  in  32  pixel; [23:16]=R, [15:8]=G, [7:0]=B, [31:24] ignored.
- `vid_datavalid`  in  1  active-pixel qualifier.
- `vid_h_sync`, `vid_v_sync`  in  1  input syncs, always active-high.
- `vid_f`, `vid_h`, `vid_v`  in  1  field/blanking flags; unused, accepted for port compatibility.
- `underflow`  in  1  one-cycle-or-longer frame-buffer underflow pulse.
- `underflow_clr`  in  1  clears `underflow_sticky`.
- `hdmi_d`  out  24  RGB to the transmitter.
- `hdmi_de`, `hdmi_hs`, `hdmi_vs`  out  1  DE and syncs to the transmitter.
- `meas_h_active`, `meas_v_active`  out  CNT_W  last captured active width and height.
- `meas_valid`  out  1  at least one complete frame has been measured.
- `lock`  out  1  geometry stable across consecutive frames.
- `frame_cnt`  out  16  count of `vid_v_sync` rising edges, wrapping.
- `underflow_sticky`  out  1  an underflow has occurred since the last clear.

## Operation
- **Pixel pipeline.** Two register stages. `hdmi_de`, `hdmi_hs` and `hdmi_vs` are delayed by exactly the same amount as `hdmi_d`.
- **Sync polarity.** `hdmi_hs = HS_POL ? hs : ~hs`. `hdmi_vs` follows the same rule with `VS_POL`.
- **Blanking.**
  - The `blank` flag is set in any cycle `underflow` is 1.
  - It clears on a `vid_v_sync` rising edge, unless `underflow` is also high that cycle; set wins.
  - While `blank` is 1, stage 1 loads `hdmi_d` data as 0. DE and syncs still pass through.
- **Line counting.**
  - `hcnt` increments on each cycle with `vid_datavalid`=1 and saturates at 2^CNT_W-1.
  - On a `vid_datavalid` falling edge: `line_len` <= `hcnt`, `hcnt` <= 0, and `vcnt` increments (saturating).
- **Frame events.** The `vid_v_sync` rising edge (`vs_rise`) comes from a 1-cycle registered copy of `vid_v_sync`.
  - On `vs_rise`, `frame_cnt` increments, wrapping 0xFFFF -> 0.
  - On `vs_rise`, `vcnt` and `hcnt` clear.
- **Lock FSM.** `lock` = (state == LOCKED).
  - IDLE: on `vs_rise` -> FIRST. This first, partial frame is discarded.
  - FIRST: on `vs_rise`, capture `meas_h_active` <= `line_len` and `meas_v_active` <= `vcnt`, set `meas_valid` = 1, go to CHECK.
  - CHECK: on `vs_rise`, capture. If the new pair equals the previous pair, go to LOCKED; otherwise stay in CHECK.
  - LOCKED: on `vs_rise`, capture. On mismatch, go to CHECK.
  - Underflow in FIRST, CHECK or LOCKED forces CHECK. If `vs_rise` arrives in the same cycle, the capture still happens but the state goes to CHECK.
- **Sticky flag.** `underflow_sticky` is set by `underflow` and cleared by `underflow_clr`. If both are high in the same cycle, set wins.
- `meas_valid` stays 1 until reset.

## Timing
- **Reset values (asynchronous).**
  - `hdmi_d`=0, `hdmi_de`=0.
  - `hdmi_hs`=~HS_POL and `hdmi_vs`=~VS_POL, i.e. the inactive levels.
  - Measurements = 0, `meas_valid`=0, `lock`=0, `frame_cnt`=0, `underflow_sticky`=0, `blank`=0, FSM=IDLE.
- **Pipeline latency.** Any input at cycle N appears on the HDMI outputs at cycle N+2.
- **Status latency.** `frame_cnt`, measurements and FSM state update 2 cycles after `vid_v_sync` rises: 1 cycle for the edge register, 1 for the capture. `underflow_sticky` rises 1 cycle after `underflow`.
- **Reset mid-line or mid-frame.** Everything returns to the reset values. The next frame is treated as a partial frame and discarded by IDLE.
- No handshake: the block never back-pressures. One input sample is consumed every cycle.

## Test plan
- **Reset state.** Assert reset with HS_POL=0 and VS_POL=1 -> `hdmi_hs`=1, `hdmi_vs`=0, `hdmi_d`=0, `lock`=0, `frame_cnt`=0.
- **Latency and mapping.** Drive `vid_data`=0xAA123456 with DE high at cycle 10 -> `hdmi_d`=0x123456 and `hdmi_de`=1 at cycle 12, with syncs aligned to the data.
- **Geometry and lock.** Drive an 8x4 active frame (total 16x8), repeated.
  - After the 2nd `vs_rise`: `meas_h_active`=8, `meas_v_active`=4, `meas_valid`=1, `lock`=0.
  - After the 3rd `vs_rise`: `lock`=1.
- **Mismatch.** Once locked, drive one frame with 6 active pixels per line -> `lock` drops after that `vs_rise` and `meas_h_active`=6. Two 6-wide frames -> relock.
- **Underflow.**
  - Pulse `underflow` mid-frame -> `hdmi_d`=0 from 2 cycles later; `lock`=0; `underflow_sticky`=1. Data resumes after the next `vs_rise`.
  - Assert `underflow` and `underflow_clr` together -> `underflow_sticky` stays 1.
- **Frame counter wrap.** Preload the counter to 0xFFFF via 65535 short frames (or a force) -> the next `vs_rise` gives `frame_cnt`=0.
